evo_gpio_port: RTL and testbench

- Parametrised CSR-mapped GPIO port: the generic successor to the fixed per-port D/E/F/G/Z constant sets.
- One instance per port.
- Provides DIR and OUT registers, each with atomic CLR/SET/TGL aliases, plus a synchronised IN register.
- Adds per-pin edge-selectable pin-change detection with a W1C flag register and an aggregated interrupt to the EXTINT controller.

---
 rtl/evo_gpio_port_pkg.sv | 30 +++
 rtl/evo_gpio_port_if.sv | 23 ++
 rtl/evo_gpio_port_insync.sv | 66 ++++++
 rtl/evo_gpio_port.sv | 140 ++++++++++++++
 tb/tb_evo_gpio_port.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/evo_gpio_port_pkg.sv
// Shared constants for the CSR-mapped GPIO port.
// Register offsets, edge-mode encoding and CSR bus widths.
package evo_gpio_port_pkg;

    localparam int CSR_AWIDTH = 12;
    localparam int CSR_DWIDTH = 32;

    localparam int EVO_PORT_NUMREGS = 12;

    localparam logic [3:0] EVO_PORT_DIR_OFS    = 4'd0;
    localparam logic [3:0] EVO_PORT_DIRCLR_OFS = 4'd1;
    localparam logic [3:0] EVO_PORT_DIRSET_OFS = 4'd2;
    localparam logic [3:0] EVO_PORT_DIRTGL_OFS = 4'd3;
    localparam logic [3:0] EVO_PORT_OUT_OFS    = 4'd4;
    localparam logic [3:0] EVO_PORT_OUTCLR_OFS = 4'd5;
    localparam logic [3:0] EVO_PORT_OUTSET_OFS = 4'd6;
    localparam logic [3:0] EVO_PORT_OUTTGL_OFS = 4'd7;
    localparam logic [3:0] EVO_PORT_IN_OFS     = 4'd8;
    localparam logic [3:0] EVO_PORT_CTRL_OFS   = 4'd9;
    localparam logic [3:0] EVO_PORT_PCMSK_OFS  = 4'd10;
    localparam logic [3:0] EVO_PORT_PCIFR_OFS  = 4'd11;

    typedef enum logic [1:0] {
        EDGE_ANY,
        EDGE_RISE,
        EDGE_FALL,
        EDGE_OFF
    } evo_port_edge_t;

endpackage

// File: rtl/evo_gpio_port_if.sv
// CSR bus bundle for the GPIO port.
// Master drives address/strobes, slave returns registered read data.
interface evo_gpio_port_if;
    import evo_gpio_port_pkg::*;

    logic [CSR_AWIDTH-1:0] csr_address;
    logic                  csr_write;
    logic                  csr_read;
    logic [CSR_DWIDTH-1:0] csr_writedata;
    logic [CSR_DWIDTH-1:0] csr_readdata;
    logic                  csr_readdatavalid;

    modport master (
        output csr_address, csr_write, csr_read, csr_writedata,
        input  csr_readdata, csr_readdatavalid
    );

    modport slave (
        input  csr_address, csr_write, csr_read, csr_writedata,
        output csr_readdata, csr_readdatavalid
    );

endinterface

// File: rtl/evo_gpio_port_insync.sv
// Pad input synchroniser, optional glitch filter and edge detector.
// Glitch filter enabled by defining EVO_PORT_GLITCH_FILTER_EN.
module evo_gpio_port_insync #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] i_pad,
    output logic [DWIDTH-1:0] o_level,
    output logic [DWIDTH-1:0] o_rise,
    output logic [DWIDTH-1:0] o_fall
);

    logic [DWIDTH-1:0] r_sync1;
    logic [DWIDTH-1:0] r_sync2;
    logic [DWIDTH-1:0] r_prev;
    logic [DWIDTH-1:0] w_level;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
        end
    end

`ifdef EVO_PORT_GLITCH_FILTER_EN
    logic [DWIDTH-1:0] r_filt;
    logic [1:0]        r_cnt [DWIDTH];

    // Follow sync only after three consecutive differing samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_filt <= '0;
            for (int i = 0; i < DWIDTH; i++) r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < DWIDTH; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= 2'd0;
                end else if (r_cnt[i] == 2'd2) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= 2'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 2'd1;
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_prev <= '0;
        else       r_prev <= w_level;
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/evo_gpio_port.sv
// CSR-mapped GPIO port: DIR/OUT with CLR/SET/TGL aliases, IN, pin-change IRQ.
// Optional input glitch filter: define EVO_PORT_GLITCH_FILTER_EN.
module evo_gpio_port
    import evo_gpio_port_pkg::*;
#(
    parameter int                    DWIDTH        = 32,
    parameter logic [31:0]           PADMASK       = 32'hFFFFFFFF,
    parameter logic [CSR_AWIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [31:0]           DIR_RST_VAL   = 32'h0,
    parameter logic [31:0]           OUT_RST_VAL   = 32'h0,
    parameter logic [31:0]           PCMSK_RST_VAL = 32'h0,
    parameter logic [31:0]           CTRL_RST_VAL  = 32'h0
) (
    input  logic              clk,
    input  logic              rstn,
    evo_gpio_port_if.slave    csr,
    input  logic [DWIDTH-1:0] pad_in,
    output logic [DWIDTH-1:0] pad_out,
    output logic [DWIDTH-1:0] pad_oe,
    output logic              pcint_irq
);

    localparam logic [DWIDTH-1:0] MASK = PADMASK[DWIDTH-1:0];

    logic [DWIDTH-1:0]     r_dir;
    logic [DWIDTH-1:0]     r_out;
    logic [DWIDTH-1:0]     r_pcmsk;
    logic [DWIDTH-1:0]     r_pcifr;
    evo_port_edge_t        r_ctrl;
    logic                  r_irq;
    logic                  r_rvalid;
    logic [CSR_DWIDTH-1:0] r_rdata;

    logic [CSR_AWIDTH-1:0] w_ofs;
    logic                  w_hit;
    logic [3:0]            w_idx;
    logic                  w_wr;
    logic                  w_rd;
    logic [DWIDTH-1:0]     w_d;
    logic [DWIDTH-1:0]     w_level;
    logic [DWIDTH-1:0]     w_rise;
    logic [DWIDTH-1:0]     w_fall;
    logic [DWIDTH-1:0]     w_evt;
    logic [DWIDTH-1:0]     w_w1c;
    logic [DWIDTH-1:0]     w_rval;

    evo_gpio_port_insync #(.DWIDTH(DWIDTH)) u_insync (
        .clk     (clk),
        .rstn    (rstn),
        .i_pad   (pad_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Modular subtract: addresses below BASE_ADDR wrap high and miss.
    assign w_ofs = csr.csr_address - BASE_ADDR;
    assign w_hit = w_ofs < CSR_AWIDTH'(EVO_PORT_NUMREGS);
    assign w_idx = w_ofs[3:0];
    assign w_wr  = csr.csr_write & w_hit;
    assign w_rd  = csr.csr_read & w_hit;
    assign w_d   = csr.csr_writedata[DWIDTH-1:0] & MASK;

    function automatic logic [DWIDTH-1:0] f_alias(
        input logic [DWIDTH-1:0] cur,
        input logic [DWIDTH-1:0] d,
        input logic [1:0]        op
    );
        logic [DWIDTH-1:0] res;
        unique case (op)
            2'd0:    res = d;
            2'd1:    res = cur & ~d;
            2'd2:    res = cur | d;
            default: res = cur ^ d;
        endcase
        return res & MASK;
    endfunction

    always_comb begin
        w_evt = '0;
        unique case (r_ctrl)
            EDGE_ANY:  w_evt = w_rise | w_fall;
            EDGE_RISE: w_evt = w_rise;
            EDGE_FALL: w_evt = w_fall;
            default:   w_evt = '0;
        endcase
        w_evt = w_evt & r_pcmsk & MASK;
    end

    assign w_w1c = (w_wr && w_idx == EVO_PORT_PCIFR_OFS) ? w_d : '0;

    always_comb begin
        w_rval = '0;
        case (w_idx)
            EVO_PORT_DIR_OFS, EVO_PORT_DIRCLR_OFS,
            EVO_PORT_DIRSET_OFS, EVO_PORT_DIRTGL_OFS: w_rval = r_dir;
            EVO_PORT_OUT_OFS, EVO_PORT_OUTCLR_OFS,
            EVO_PORT_OUTSET_OFS, EVO_PORT_OUTTGL_OFS: w_rval = r_out;
            EVO_PORT_IN_OFS:    w_rval = w_level & MASK;
            EVO_PORT_CTRL_OFS:  w_rval = DWIDTH'(r_ctrl);
            EVO_PORT_PCMSK_OFS: w_rval = r_pcmsk;
            EVO_PORT_PCIFR_OFS: w_rval = r_pcifr;
            default:            w_rval = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dir    <= DIR_RST_VAL[DWIDTH-1:0] & MASK;
            r_out    <= OUT_RST_VAL[DWIDTH-1:0] & MASK;
            r_pcmsk  <= PCMSK_RST_VAL[DWIDTH-1:0] & MASK;
            r_ctrl   <= evo_port_edge_t'(CTRL_RST_VAL[1:0]);
            r_pcifr  <= '0;
            r_irq    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_wr && w_idx[3:2] == 2'b00)
                r_dir <= f_alias(r_dir, w_d, w_idx[1:0]);
            if (w_wr && w_idx[3:2] == 2'b01)
                r_out <= f_alias(r_out, w_d, w_idx[1:0]);
            if (w_wr && w_idx == EVO_PORT_CTRL_OFS)
                r_ctrl <= evo_port_edge_t'(csr.csr_writedata[1:0]);
            if (w_wr && w_idx == EVO_PORT_PCMSK_OFS)
                r_pcmsk <= w_d;
            // New events override a same-cycle W1C.
            r_pcifr  <= (r_pcifr & ~w_w1c) | w_evt;
            r_irq    <= |r_pcifr;
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? CSR_DWIDTH'(w_rval) : '0;
        end
    end

    assign pad_out               = r_out;
    assign pad_oe                = r_dir;
    assign pcint_irq             = r_irq;
    assign csr.csr_readdata      = r_rdata;
    assign csr.csr_readdatavalid = r_rvalid;

endmodule

// File: tb/tb_evo_gpio_port.sv
// Self-checking bench for evo_gpio_port with a history-based reference model.
// Filter-specific steps run when EVO_PORT_GLITCH_FILTER_EN is defined.
module tb_evo_gpio_port;
    import evo_gpio_port_pkg::*;

    localparam logic [31:0] PMASK  = 32'h03803f73;
    localparam logic [11:0] BASE   = 12'h040;
    localparam logic [31:0] DIR_RV = 32'h0000000F;
    localparam logic [31:0] OUT_RV = 32'h00000055;
`ifdef EVO_PORT_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pad_in;
    logic [31:0] pad_out;
    logic [31:0] pad_oe;
    logic        pcint_irq;
    logic [31:0] pad;

    evo_gpio_port_if ifc ();

    evo_gpio_port #(
        .DWIDTH        (32),
        .PADMASK       (PMASK),
        .BASE_ADDR     (BASE),
        .DIR_RST_VAL   (DIR_RV),
        .OUT_RST_VAL   (OUT_RV),
        .PCMSK_RST_VAL (32'h0),
        .CTRL_RST_VAL  (32'h0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .csr       (ifc),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .pcint_irq (pcint_irq)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: architectural registers plus per-cycle pad history.
    logic [31:0] m_dir, m_out, m_pcmsk, m_pcifr, m_rdata;
    logic [1:0]  m_ctrl;
    logic        m_irq, m_rvalid;
    logic [31:0] hist [0:4095];
    logic [31:0] lvl  [0:4095];
    int          n = 0;
    int          rst_at = 0;

    function automatic logic [31:0] H(input int k);
        return (k <= rst_at) ? 32'h0 : hist[k];
    endfunction

    function automatic logic [31:0] L(input int k);
        return (k <= rst_at) ? 32'h0 : lvl[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dir    = DIR_RV & PMASK;
        m_out    = OUT_RV & PMASK;
        m_pcmsk  = 32'h0;
        m_ctrl   = 2'd0;
        m_pcifr  = 32'h0;
        m_irq    = 1'b0;
        m_rdata  = 32'h0;
        m_rvalid = 1'b0;
        rst_at   = n;
    endtask

    task automatic model_edge(input logic [11:0] a, input logic wr,
                              input logic rd, input logic [31:0] wd);
        logic [11:0] off;
        logic [31:0] l1, l2, ev, rv, d, eq;
        bit hit;
        n++;
        hist[n] = pad;
        l1 = L(n - 1);
        l2 = L(n - 2);
        case (m_ctrl)
            2'd0:    ev = l1 ^ l2;
            2'd1:    ev = l1 & ~l2;
            2'd2:    ev = ~l1 & l2;
            default: ev = 32'h0;
        endcase
        ev = ev & m_pcmsk & PMASK;
        if (FILT) begin
            eq = ~(H(n-2) ^ H(n-3)) & ~(H(n-3) ^ H(n-4));
            lvl[n] = (eq & H(n-2)) | (~eq & L(n-1));
        end else begin
            lvl[n] = H(n - 1);
        end
        off = a - BASE;
        hit = off < 12;
        if (off < 4)        rv = m_dir;
        else if (off < 8)   rv = m_out;
        else if (off == 8)  rv = l1 & PMASK;
        else if (off == 9)  rv = {30'h0, m_ctrl};
        else if (off == 10) rv = m_pcmsk;
        else                rv = m_pcifr;
        m_rvalid = rd && hit;
        m_rdata  = (rd && hit) ? rv : 32'h0;
        m_irq    = |m_pcifr;
        if (wr && hit) begin
            d = wd & PMASK;
            case (off)
                0:  m_dir = d;
                1:  m_dir = m_dir & ~d;
                2:  m_dir = m_dir | d;
                3:  m_dir = m_dir ^ d;
                4:  m_out = d;
                5:  m_out = m_out & ~d;
                6:  m_out = m_out | d;
                7:  m_out = m_out ^ d;
                9:  m_ctrl = wd[1:0];
                10: m_pcmsk = d;
                11: m_pcifr = m_pcifr & ~d;
                default: ;
            endcase
        end
        m_pcifr = m_pcifr | ev;
    endtask

    task automatic step(input logic [11:0] a, input logic wr,
                        input logic rd, input logic [31:0] wd);
        @(negedge clk);
        ifc.csr_address   = a;
        ifc.csr_write     = wr;
        ifc.csr_read      = rd;
        ifc.csr_writedata = wd;
        pad_in            = pad;
        @(posedge clk);
        model_edge(a, wr, rd, wd);
        #1;
        chk("pad_out", pad_out, m_out);
        chk("pad_oe", pad_oe, m_dir);
        chk("readdata", ifc.csr_readdata, m_rdata);
        chk("rvalid", {31'h0, ifc.csr_readdatavalid}, {31'h0, m_rvalid});
        chk("irq", {31'h0, pcint_irq}, {31'h0, m_irq});
    endtask

    task automatic idle();
        step(BASE, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        pad = 32'h0;
        pad_in = 32'h0;
        ifc.csr_address = '0;
        ifc.csr_write = 1'b0;
        ifc.csr_read = 1'b0;
        ifc.csr_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pad_oe", pad_oe, 32'h00000003);
        chk("rst_pad_out", pad_out, 32'h00000051);
        chk("rst_rdata", ifc.csr_readdata, 32'h0);
        chk("rst_rvalid", {31'h0, ifc.csr_readdatavalid}, 32'h0);
        chk("rst_irq", {31'h0, pcint_irq}, 32'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        step(BASE + 12'd0, 1'b0, 1'b1, 32'h0);
        chk("dir_read", ifc.csr_readdata, 32'h00000003);
        chk("dir_rvalid", {31'h0, ifc.csr_readdatavalid}, 32'h1);
        idle();
        chk("rvalid_once", {31'h0, ifc.csr_readdatavalid}, 32'h0);

        step(BASE + 12'd4, 1'b1, 1'b0, 32'hFFFFFFFF);
        step(BASE + 12'd5, 1'b1, 1'b0, 32'h00000011);
        step(BASE + 12'd7, 1'b1, 1'b0, 32'h00000102);
        step(BASE + 12'd6, 1'b0, 1'b1, 32'h0);
        chk("out_alias", ifc.csr_readdata, 32'h03803e60);
        chk("out_pad", pad_out, 32'h03803e60);

        step(BASE + 12'd12, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk("miss_hi", {31'h0, ifc.csr_readdatavalid}, 32'h0);
        step(BASE - 12'd1, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk("miss_lo", {31'h0, ifc.csr_readdatavalid}, 32'h0);
        step(BASE + 12'd0, 1'b0, 1'b1, 32'h0);
        chk("miss_dir", ifc.csr_readdata, 32'h00000003);

`ifndef EVO_PORT_GLITCH_FILTER_EN
        step(BASE + 12'd10, 1'b1, 1'b0, 32'h1);
        step(BASE + 12'd9, 1'b1, 1'b0, 32'h1);
        pad = 32'h1;
        idle();
        idle();
        step(BASE + 12'd11, 1'b0, 1'b1, 32'h0);
        chk("pcifr_pre", ifc.csr_readdata, 32'h0);
        chk("irq_pre", {31'h0, pcint_irq}, 32'h0);
        step(BASE + 12'd11, 1'b0, 1'b1, 32'h0);
        chk("pcifr_set", ifc.csr_readdata, 32'h1);
        chk("irq_set", {31'h0, pcint_irq}, 32'h1);
        pad = 32'h0;
        repeat (4) idle();
        step(BASE + 12'd11, 1'b1, 1'b0, 32'h1);
        chk("irq_hold", {31'h0, pcint_irq}, 32'h1);
        step(BASE + 12'd11, 1'b0, 1'b1, 32'h0);
        chk("pcifr_w1c", ifc.csr_readdata, 32'h0);
        chk("irq_drop", {31'h0, pcint_irq}, 32'h0);
        pad = 32'h1;
        idle();
        idle();
        step(BASE + 12'd11, 1'b1, 1'b0, 32'h1);
        step(BASE + 12'd10, 1'b1, 1'b1, 32'h0);
        step(BASE + 12'd11, 1'b0, 1'b1, 32'h0);
        chk("set_wins", ifc.csr_readdata, 32'h1);
        step(BASE + 12'd11, 1'b1, 1'b0, 32'hFFFFFFFF);
`else
        step(BASE + 12'd10, 1'b1, 1'b0, 32'h10);
        pad = 32'h10;
        idle();
        idle();
        pad = 32'h0;
        repeat (6) begin
            step(BASE + 12'd8, 1'b0, 1'b1, 32'h0);
            chk("glitch_in", ifc.csr_readdata & 32'h10, 32'h0);
        end
        step(BASE + 12'd11, 1'b0, 1'b1, 32'h0);
        chk("glitch_flag", ifc.csr_readdata, 32'h0);
        pad = 32'h10;
        for (int i = 1; i <= 6; i++) begin
            if (i == 5) pad = 32'h0;
            step(BASE + 12'd8, 1'b0, 1'b1, 32'h0);
            if (i == 5) chk("filt_pre", ifc.csr_readdata & 32'h10, 32'h0);
            if (i == 6) chk("filt_in", ifc.csr_readdata & 32'h10, 32'h10);
        end
`endif

        repeat (400) begin
            logic [11:0] a;
            a = BASE + 12'($urandom_range(0, 13)) - 12'd1;
            if ($urandom_range(0, 2) == 0) pad = $urandom;
            step(a, 1'($urandom), 1'($urandom), $urandom);
        end

        @(negedge clk);
        ifc.csr_address = BASE;
        ifc.csr_write = 1'b0;
        ifc.csr_read = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("arst_oe", pad_oe, 32'h00000003);
        chk("arst_out", pad_out, 32'h00000051);
        chk("arst_rvalid", {31'h0, ifc.csr_readdatavalid}, 32'h0);
        chk("arst_irq", {31'h0, pcint_irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("arst_drop", {31'h0, ifc.csr_readdatavalid}, 32'h0);
        @(negedge clk);
        ifc.csr_read = 1'b0;
        rstn = 1'b1;
        model_reset();
        idle();
        step(BASE + 12'd0, 1'b0, 1'b1, 32'h0);
        chk("post_rst_dir", ifc.csr_readdata, 32'h00000003);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
